// File: rtl/l2_parser_pkg.sv
// Shared types and default sizing for the L2 parser front end.
package l2_parser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } seq_state_e;

    localparam int L2_HDR_MIN_BYTES_DEF = 14;
    localparam int L2_HDR_MAX_BYTES_DEF = 18;
    localparam int MAX_FRAME_BYTES_DEF  = 1522;

endpackage

// File: rtl/keep_popcount.sv
// Combinational population count of a byte-enable (tkeep) vector.
module keep_popcount #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  keep,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/l2_frame_seq_ctrl.sv
// Frame sequencer: AXI-Stream handshakes -> L2 parser control strobes.
// Optional statistics counters are built when L2_FRAME_SEQ_STATS_EN is defined.
module l2_frame_seq_ctrl
    import l2_parser_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int L2_HEADER_MIN_BYTES = L2_HDR_MIN_BYTES_DEF,
    parameter int L2_HEADER_MAX_BYTES = L2_HDR_MAX_BYTES_DEF,
    parameter int MAX_FRAME_BYTES     = MAX_FRAME_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [DATA_WIDTH/8-1:0] s_keep,
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic                    frame_start,
    output logic                    beat_accept,
    output logic                    frame_end,
    output logic                    hdr_beat,
    output logic [$clog2(L2_HEADER_MAX_BYTES/(DATA_WIDTH/8)+2)-1:0] hdr_beat_idx,
    output logic                    hdr_done,
    output logic                    runt_err,
    output logic                    oversize_err,
`ifdef L2_FRAME_SEQ_STATS_EN
    input  logic                    stat_clr,
    output logic [31:0]             stat_frames,
    output logic [31:0]             stat_runts,
    output logic [31:0]             stat_drops,
`endif
    output logic                    busy
);

    localparam int BPB = DATA_WIDTH / 8;
    localparam int BW  = $clog2(MAX_FRAME_BYTES + BPB + 1);
    localparam int IW  = $clog2(L2_HEADER_MAX_BYTES / BPB + 2);
    localparam int PCW = $clog2(BPB + 1);

    localparam logic [BW-1:0] HDR_MIN_B = BW'(L2_HEADER_MIN_BYTES);
    localparam logic [BW-1:0] HDR_MAX_B = BW'(L2_HEADER_MAX_BYTES);
    localparam logic [BW-1:0] MAX_FR_B  = BW'(MAX_FRAME_BYTES);

    seq_state_e      state_q, state_d;
    logic [BW-1:0]   bytes_seen_q, bytes_seen_d;
    logic [IW-1:0]   beat_idx_q, beat_idx_d;
    logic            hdr_done_q, hdr_done_d;
    logic            runt_err_q, runt_err_d;
    logic            oversize_err_q, oversize_err_d;

    logic [PCW-1:0]  keep_cnt;
    logic [BW:0]     sum_ext;
    logic [BW-1:0]   new_total;
    logic            acc;

    keep_popcount #(.W(BPB), .CW(PCW)) u_keep_popcount (
        .keep  (s_keep),
        .count (keep_cnt)
    );

    assign s_ready = (state_q == DROP) ? 1'b1 : m_ready;
    assign m_valid = s_valid & (state_q != DROP);
    assign acc     = s_valid & s_ready;

    // First beat restarts the count; later beats accumulate and saturate.
    assign sum_ext   = {1'b0, bytes_seen_q} + (BW + 1)'(keep_cnt);
    assign new_total = (state_q == IDLE) ? BW'(keep_cnt)
                     : (sum_ext[BW] ? {BW{1'b1}} : sum_ext[BW-1:0]);

    always_comb begin
        state_d        = state_q;
        bytes_seen_d   = bytes_seen_q;
        beat_idx_d     = beat_idx_q;
        hdr_done_d     = 1'b0;
        runt_err_d     = 1'b0;
        oversize_err_d = 1'b0;
        frame_start    = 1'b0;
        beat_accept    = 1'b0;
        frame_end      = 1'b0;
        hdr_beat       = 1'b0;
        hdr_beat_idx   = '0;
        if (acc) begin
            bytes_seen_d = new_total;
            unique case (state_q)
                IDLE: begin
                    frame_start = 1'b1;
                    beat_accept = 1'b1;
                    hdr_beat    = 1'b1;
                    if (s_last) begin
                        frame_end  = 1'b1;
                        hdr_done_d = (new_total >= HDR_MIN_B);
                        runt_err_d = (new_total <  HDR_MIN_B);
                    end else if (new_total >= HDR_MAX_B) begin
                        hdr_done_d = 1'b1;
                        state_d    = BODY;
                    end else begin
                        beat_idx_d = IW'(1);
                        state_d    = HDR;
                    end
                end
                HDR: begin
                    hdr_beat     = 1'b1;
                    hdr_beat_idx = beat_idx_q;
                    beat_accept  = 1'b1;
                    if (beat_idx_q != {IW{1'b1}}) begin
                        beat_idx_d = beat_idx_q + IW'(1);
                    end
                    if (s_last) begin
                        frame_end  = 1'b1;
                        hdr_done_d = (new_total >= HDR_MIN_B);
                        runt_err_d = (new_total <  HDR_MIN_B);
                        state_d    = IDLE;
                    end else if (new_total > MAX_FR_B) begin
                        // Only reachable when the frame limit is below the header window.
                        beat_accept    = 1'b0;
                        oversize_err_d = 1'b1;
                        state_d        = DROP;
                    end else if (new_total >= HDR_MAX_B) begin
                        hdr_done_d = 1'b1;
                        state_d    = BODY;
                    end
                end
                BODY: begin
                    if (s_last) begin
                        beat_accept = 1'b1;
                        frame_end   = 1'b1;
                        state_d     = IDLE;
                    end else if (new_total > MAX_FR_B) begin
                        oversize_err_d = 1'b1;
                        state_d        = DROP;
                    end else begin
                        beat_accept = 1'b1;
                    end
                end
                DROP: begin
                    if (s_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bytes_seen_q   <= '0;
            beat_idx_q     <= '0;
            hdr_done_q     <= 1'b0;
            runt_err_q     <= 1'b0;
            oversize_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bytes_seen_q   <= bytes_seen_d;
            beat_idx_q     <= beat_idx_d;
            hdr_done_q     <= hdr_done_d;
            runt_err_q     <= runt_err_d;
            oversize_err_q <= oversize_err_d;
        end
    end

    assign hdr_done     = hdr_done_q;
    assign runt_err     = runt_err_q;
    assign oversize_err = oversize_err_q;
    assign busy         = (state_q != IDLE);

`ifdef L2_FRAME_SEQ_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d;
    logic [31:0] stat_runts_q, stat_runts_d;
    logic [31:0] stat_drops_q, stat_drops_d;

    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_runts_d  = stat_runts_q;
        stat_drops_d  = stat_drops_q;
        if (stat_clr) begin
            stat_frames_d = '0;
            stat_runts_d  = '0;
            stat_drops_d  = '0;
        end else begin
            if (frame_end && !runt_err_d && stat_frames_q != '1) stat_frames_d = stat_frames_q + 32'd1;
            if (runt_err_q && stat_runts_q != '1) stat_runts_d = stat_runts_q + 32'd1;
            if (oversize_err_q && stat_drops_q != '1) stat_drops_d = stat_drops_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_runts_q  <= '0;
            stat_drops_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_runts_q  <= stat_runts_d;
            stat_drops_q  <= stat_drops_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_runts  = stat_runts_q;
    assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_l2_frame_seq_ctrl.sv
// Directed table-driven bench for l2_frame_seq_ctrl (default build).
module tb_l2_frame_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last, m_ready, m_valid;
    logic [7:0] s_keep;
    logic       frame_start, beat_accept, frame_end, hdr_beat;
    logic [1:0] hdr_beat_idx;
    logic       hdr_done, runt_err, oversize_err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    l2_frame_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_last       (s_last),
        .s_keep       (s_keep),
        .m_ready      (m_ready),
        .m_valid      (m_valid),
        .frame_start  (frame_start),
        .beat_accept  (beat_accept),
        .frame_end    (frame_end),
        .hdr_beat     (hdr_beat),
        .hdr_beat_idx (hdr_beat_idx),
        .hdr_done     (hdr_done),
        .runt_err     (runt_err),
        .oversize_err (oversize_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        last;
        logic [7:0]  keep;
        logic        mr;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Bit order: s_ready m_valid fs ba fe hb idx[1:0] hd runt ovs busy
    function automatic logic [11:0] e(input logic sr, mv, fs, ba, fe, hb,
                                      input logic [1:0] idx,
                                      input logic hd, rt, ov, bz);
        return {sr, mv, fs, ba, fe, hb, idx, hd, rt, ov, bz};
    endfunction

    task automatic addv(input logic v, l, input logic [7:0] k, input logic mr,
                        input logic [11:0] x);
        vec_t t;
        t.v = v; t.last = l; t.keep = k; t.mr = mr; t.exp = x;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then advance past the next edge.
    task automatic apply(input logic v, l, input logic [7:0] k, input logic mr,
                         input logic [11:0] x, input string nm, input int id);
        logic [11:0] act;
        s_valid = v; s_last = l; s_keep = k; m_ready = mr;
        #4;
        act = {s_ready, m_valid, frame_start, beat_accept, frame_end, hdr_beat,
               hdr_beat_idx, hdr_done, runt_err, oversize_err, busy};
        if (!x[6]) act[5:4] = 2'b00;
        n_checks++;
        if (act !== x)
            $display("FAIL %s[%0d] got=%b want=%b (sr mv fs ba fe hb idx hd rt ov bz)",
                     nm, id, act, x);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] x;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_keep = 8'h00; m_ready = 1'b1;

        // 64-byte frame, full keep
        addv(1,0,8'hFF,1, e(1,1,1,1,0,1,2'd0,0,0,0,0));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,1,2'd1,0,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,1,2'd2,0,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,0,2'd0,1,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,0,2'd0,0,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,0,2'd0,0,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,0,2'd0,0,0,0,1));
        addv(1,1,8'hFF,1, e(1,1,0,1,1,0,2'd0,0,0,0,1));
        addv(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,0,0,0));
        // 4-byte runt, single beat
        addv(1,1,8'h0F,1, e(1,1,1,1,1,1,2'd0,0,0,0,0));
        addv(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,1,0,0));
        // 14-byte minimum frame over two beats
        addv(1,0,8'hFF,1, e(1,1,1,1,0,1,2'd0,0,0,0,0));
        addv(1,1,8'h3F,1, e(1,1,0,1,1,1,2'd1,0,0,0,1));
        addv(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,1,0,0,0));
        // 24-byte frame with m_ready toggling
        addv(1,0,8'hFF,0, e(0,1,0,0,0,0,2'd0,0,0,0,0));
        addv(1,0,8'hFF,1, e(1,1,1,1,0,1,2'd0,0,0,0,0));
        addv(1,0,8'hFF,0, e(0,1,0,0,0,0,2'd0,0,0,0,1));
        addv(1,0,8'hFF,1, e(1,1,0,1,0,1,2'd1,0,0,0,1));
        addv(1,1,8'hFF,0, e(0,1,0,0,0,0,2'd0,0,0,0,1));
        addv(1,1,8'hFF,1, e(1,1,0,1,1,1,2'd2,0,0,0,1));
        addv(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,1,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        apply(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,0,0,0), "reset", 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].v, vecs[i].last, vecs[i].keep, vecs[i].mr, vecs[i].exp, "vec", i);

        n_checks++;
        if (dut.bytes_seen_q !== 11'd24)
            $display("FAIL bytes_seen got=%0d want=24", dut.bytes_seen_q);
        else
            n_pass++;

        // 200-beat oversize frame; limit crossed on beat 190 (1528 > 1522)
        for (int k = 0; k < 200; k++) begin
            if (k == 0)       x = e(1,1,1,1,0,1,2'd0,0,0,0,0);
            else if (k < 3)   x = e(1,1,0,1,0,1,2'(k),0,0,0,1);
            else if (k < 190) x = e(1,1,0,1,0,0,2'd0,(k == 3),0,0,1);
            else if (k == 190) x = e(1,1,0,0,0,0,2'd0,0,0,0,1);
            else              x = e(1,0,0,0,0,0,2'd0,0,0,(k == 191),1);
            apply(1, (k == 199), 8'hFF, (k > 190) ? 1'b0 : 1'b1, x, "big", k);
        end
        apply(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,0,0,0), "post_big", 0);
        apply(1,0,8'hFF,1, e(1,1,1,1,0,1,2'd0,0,0,0,0), "restart", 0);
        apply(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,0,0,1), "hdr_wait", 0);

        // Asynchronous reset while in HDR
        rst_n = 1'b0;
        apply(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,0,0,0,0), "mid_rst", 0);
        rst_n = 1'b1;
        apply(1,0,8'hFF,1, e(1,1,1,1,0,1,2'd0,0,0,0,0), "rst_start", 0);
        apply(1,1,8'hFF,1, e(1,1,0,1,1,1,2'd1,0,0,0,1), "rst_end", 0);
        apply(0,0,8'h00,1, e(1,0,0,0,0,0,2'd0,1,0,0,0), "rst_done", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
